// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
//   Memory / writeback stage of the 3-stage pipeline. Completes data-memory
//   accesses issued from the execute-stage register, aligns and extends load
//   data, builds store strobes and lane-replicated store data, drives the
//   register-file write port and counts retired instructions. A small FSM
//   tracks outstanding loads/stores and abandons them after MEM_TIMEOUT wait
//   cycles, raising a sticky bus_error.
//
// Optional feature macro: WB_MISALIGN_CHECK_EN
//   When defined, misaligned halfword/word accesses abort immediately
//   (no memory request, no register write, no stall, bus_error set).
//
// Parameters
//   MEM_TIMEOUT     : wait cycles before an access is abandoned (1..255)
// Ports
//   clk, reset      : clock, asynchronous active-low reset
//   wb_result       : ALU result or store data
//   wb_mem_write    : instruction is a store
//   wb_alu_to_reg   : instruction writes its destination register
//   wb_mem_to_reg   : instruction is a load
//   wb_dest_reg_sel : destination register index
//   wb_read_address : access address bits [1:0]
//   mem_alu_operation : funct3 width code (0 B, 1 H, 2 W, 4 BU, 5 HU)
//   dmem_rdata/dmem_rvalid : load data and its valid
//   dmem_wready     : memory accepts the store this cycle
//   dmem_wvalid/dmem_wdata/dmem_wstrb : store request
//   rf_we/rf_waddr/rf_wdata : register-file write port
//   stall_read      : hold the execute-to-writeback register
//   instret         : retired-instruction counter
//   bus_error       : sticky timeout / misalignment flag
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_result,
  input  logic        wb_mem_write,
  input  logic        wb_alu_to_reg,
  input  logic        wb_mem_to_reg,
  input  logic [4:0]  wb_dest_reg_sel,
  input  logic [1:0]  wb_read_address,
  input  logic [2:0]  mem_alu_operation,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  input  logic        dmem_wready,
  output logic        dmem_wvalid,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_read,
  output logic [63:0] instret,
  output logic        bus_error
);

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_WAIT  = 2'd1,
    ST_STORE_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  state_e      state_r;
  logic [7:0]  wait_cnt_r;
  logic [63:0] instret_r;
  logic        bus_error_r;

  logic        is_load_s;
  logic        is_store_s;
  logic        is_bubble_s;
  size_e       size_s;
  logic        misalign_s;
  logic        timeout_s;
  logic        abort_s;
  logic        access_done_s;
  logic        retire_s;
  logic [7:0]  load_byte_s;
  logic [15:0] load_half_s;
  logic [31:0] load_data_s;

  // Decode the instruction class, access size and abort conditions.
  always_comb begin
    is_load_s   = wb_mem_to_reg;
    // A load flagged together with a store wins; the store is dropped.
    is_store_s  = wb_mem_write & ~wb_mem_to_reg;
    is_bubble_s = ~(wb_mem_write | wb_alu_to_reg | wb_mem_to_reg);

    case (mem_alu_operation)
      3'd0, 3'd4: size_s = SZ_BYTE;
      3'd1, 3'd5: size_s = SZ_HALF;
      default:    size_s = SZ_WORD;
    endcase

`ifdef WB_MISALIGN_CHECK_EN
    if ((is_load_s | is_store_s) && (state_r == ST_IDLE)) begin
      misalign_s = ((size_s == SZ_HALF) && wb_read_address[0]) ||
                   ((size_s == SZ_WORD) && (wb_read_address != 2'd0));
    end else begin
      misalign_s = 1'b0;
    end
`else
    misalign_s = 1'b0;
`endif

    timeout_s = (state_r != ST_IDLE) && (wait_cnt_r == TIMEOUT_C);
    abort_s   = timeout_s | misalign_s;

    if (is_load_s) begin
      access_done_s = dmem_rvalid;
    end else if (is_store_s) begin
      access_done_s = dmem_wready;
    end else begin
      access_done_s = 1'b1;
    end

    // Aborted accesses still retire so the pipeline keeps moving.
    retire_s = ~is_bubble_s & (access_done_s | abort_s);
  end

  // Select and extend load data from the returned word.
  always_comb begin
    case (wb_read_address)
      2'd0:    load_byte_s = dmem_rdata[7:0];
      2'd1:    load_byte_s = dmem_rdata[15:8];
      2'd2:    load_byte_s = dmem_rdata[23:16];
      2'd3:    load_byte_s = dmem_rdata[31:24];
      default: load_byte_s = dmem_rdata[7:0];
    endcase

    if (wb_read_address[1]) begin
      load_half_s = dmem_rdata[31:16];
    end else begin
      load_half_s = dmem_rdata[15:0];
    end

    case (mem_alu_operation)
      3'd0:    load_data_s = {{24{load_byte_s[7]}}, load_byte_s};
      3'd1:    load_data_s = {{16{load_half_s[15]}}, load_half_s};
      3'd4:    load_data_s = {24'h000000, load_byte_s};
      3'd5:    load_data_s = {16'h0000, load_half_s};
      default: load_data_s = dmem_rdata;
    endcase
  end

  // Store request: replicated data, byte strobes and request valid.
  always_comb begin
    case (size_s)
      SZ_BYTE: begin
        dmem_wdata = {4{wb_result[7:0]}};
        dmem_wstrb = 4'b0001 << wb_read_address;
      end
      SZ_HALF: begin
        dmem_wdata = {2{wb_result[15:0]}};
        if (wb_read_address[1]) begin
          dmem_wstrb = 4'b1100;
        end else begin
          dmem_wstrb = 4'b0011;
        end
      end
      default: begin
        dmem_wdata = wb_result;
        dmem_wstrb = 4'hF;
      end
    endcase

    if ((state_r == ST_IDLE) || (state_r == ST_STORE_WAIT)) begin
      dmem_wvalid = is_store_s & ~abort_s;
    end else begin
      dmem_wvalid = 1'b0;
    end
  end

  // Register-file write port and pipeline stall.
  always_comb begin
    rf_waddr = wb_dest_reg_sel;

    if (wb_mem_to_reg) begin
      rf_wdata = load_data_s;
    end else begin
      rf_wdata = wb_result;
    end

    rf_we = wb_alu_to_reg & (wb_dest_reg_sel != 5'd0) &
            (~is_load_s | dmem_rvalid) & ~abort_s;

    // Dropping the stall on the handshake cycle lets the register advance
    // at the next edge, so the completed instruction is never replayed.
    stall_read = ~abort_s & ((is_load_s & ~dmem_rvalid) |
                             (is_store_s & ~dmem_wready));
  end

  // Access FSM, wait counter, retire counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 8'd0;
      instret_r   <= 64'd0;
      bus_error_r <= 1'b0;
    end else begin
      if (retire_s) begin
        instret_r <= instret_r + 64'd1;
      end else begin
        instret_r <= instret_r;
      end

      if (abort_s) begin
        bus_error_r <= 1'b1;
      end else begin
        bus_error_r <= bus_error_r;
      end

      if (abort_s) begin
        state_r    <= ST_IDLE;
        wait_cnt_r <= 8'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            // The first stalled cycle is counted on entry to a wait state,
            // so the counter equals the number of stall cycles seen so far.
            if (is_load_s && !dmem_rvalid) begin
              state_r    <= ST_LOAD_WAIT;
              wait_cnt_r <= 8'd1;
            end else if (is_store_s && !dmem_wready) begin
              state_r    <= ST_STORE_WAIT;
              wait_cnt_r <= 8'd1;
            end else begin
              state_r    <= ST_IDLE;
              wait_cnt_r <= 8'd0;
            end
          end
          ST_LOAD_WAIT: begin
            if (!is_load_s || dmem_rvalid) begin
              state_r    <= ST_IDLE;
              wait_cnt_r <= 8'd0;
            end else begin
              state_r    <= ST_LOAD_WAIT;
              wait_cnt_r <= (wait_cnt_r == 8'hFF) ? wait_cnt_r : wait_cnt_r + 8'd1;
            end
          end
          ST_STORE_WAIT: begin
            if (!is_store_s || dmem_wready) begin
              state_r    <= ST_IDLE;
              wait_cnt_r <= 8'd0;
            end else begin
              state_r    <= ST_STORE_WAIT;
              wait_cnt_r <= (wait_cnt_r == 8'hFF) ? wait_cnt_r : wait_cnt_r + 8'd1;
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 8'd0;
          end
        endcase
      end
    end
  end

  assign instret   = instret_r;
  assign bus_error = bus_error_r;

endmodule
